// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-port arbiter sequencing transactions onto one single-port data RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module ram_access_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 64,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [31:0]           addr0,
  input  logic [31:0]           addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  range_err,
  output logic                  busy,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  port_q, port_d, we_q, we_d, oor_q, oor_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic                  range_err_q, range_err_d, busy_q, busy_d;
  logic                  ram_write_en_q, ram_write_en_d, ram_read_en_q, ram_read_en_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, ram_data_write_q, ram_data_write_d;
  logic [31:0]           ram_address_q, ram_address_d, sel_addr;
  logic                  win, sel_we, sel_oor;
  logic [DATA_WIDTH-1:0] sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  ptr_q, ptr_d;
  assign win = (req0 && req1) ? !ptr_q : req1;
`else
  assign win = !req0;
`endif
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_we    = win ? we1 : we0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign sel_oor   = (sel_addr >> 2) >= 32'(MEM_WORDS);
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    port_d           = port_q;
    we_d             = we_q;
    oor_d            = oor_q;
    gnt0_d           = 1'b0;
    gnt1_d           = 1'b0;
    done0_d          = 1'b0;
    done1_d          = 1'b0;
    range_err_d      = 1'b0;
    rdata_d          = rdata_q;
    ram_address_d    = ram_address_q;
    ram_data_write_d = ram_data_write_q;
    ram_write_en_d   = 1'b0;
    ram_read_en_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d            = ptr_q;
`endif
    case (state_q)
      IDLE: if (req0 || req1) begin
        port_d  = win;
        we_d    = sel_we;
        oor_d   = sel_oor;
        gnt0_d  = !win;
        gnt1_d  = win;
        cnt_d   = 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = win;
`endif
        state_d = sel_oor ? RESP : ACCESS;
        if (!sel_oor) begin
          ram_address_d    = sel_addr;
          ram_read_en_d    = !sel_we;
          ram_write_en_d   = sel_we;
          ram_data_write_d = sel_we ? sel_wdata : ram_data_write_q;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ACCESS_CYCLES - 1)) begin
          state_d = RESP;
          rdata_d = we_q ? rdata_q : ram_data_out;
        end else
          ram_read_en_d = !we_q;
      end
      RESP: begin
        state_d     = IDLE;
        done0_d     = !port_q;
        done1_d     = port_q;
        range_err_d = oor_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      port_q           <= 1'b0;
      we_q             <= 1'b0;
      oor_q            <= 1'b0;
      gnt0_q           <= 1'b0;
      gnt1_q           <= 1'b0;
      done0_q          <= 1'b0;
      done1_q          <= 1'b0;
      range_err_q      <= 1'b0;
      busy_q           <= 1'b0;
      rdata_q          <= '0;
      ram_address_q    <= '0;
      ram_data_write_q <= '0;
      ram_write_en_q   <= 1'b0;
      ram_read_en_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q            <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      port_q           <= port_d;
      we_q             <= we_d;
      oor_q            <= oor_d;
      gnt0_q           <= gnt0_d;
      gnt1_q           <= gnt1_d;
      done0_q          <= done0_d;
      done1_q          <= done1_d;
      range_err_q      <= range_err_d;
      busy_q           <= busy_d;
      rdata_q          <= rdata_d;
      ram_address_q    <= ram_address_d;
      ram_data_write_q <= ram_data_write_d;
      ram_write_en_q   <= ram_write_en_d;
      ram_read_en_q    <= ram_read_en_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q            <= ptr_d;
`endif
    end
  end
  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign rdata          = rdata_q;
  assign range_err      = range_err_q;
  assign busy           = busy_q;
  assign ram_address    = ram_address_q;
  assign ram_data_write = ram_data_write_q;
  assign ram_write_en   = ram_write_en_q;
  assign ram_read_en    = ram_read_en_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: random two-port traffic against a transaction-level model of the arbiter and RAM.
module tb_ram_access_arbiter;
  localparam int DW = 32, MW = 64, AC = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, done0, done1, range_err, busy, ram_write_en, ram_read_en;
  logic [DW-1:0] rdata, ram_data_write, ram_data_out;
  logic [31:0] ram_address;
  always #5 clk = ~clk;
  ram_access_arbiter #(.DATA_WIDTH(DW), .MEM_WORDS(MW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .range_err(range_err), .busy(busy), .ram_address(ram_address),
    .ram_data_write(ram_data_write), .ram_write_en(ram_write_en),
    .ram_read_en(ram_read_en), .ram_data_out(ram_data_out));
  logic [DW-1:0] mem [MW];
  logic fill = 1'b0;
  int fill_idx = 0;
  logic [DW-1:0] fill_val = '0;
  assign ram_data_out = mem[ram_address[7:2]];
  always @(posedge clk)
    if (fill) mem[fill_idx] <= fill_val;
    else if (ram_write_en) mem[ram_address[7:2]] <= ram_data_write;
  int total = 0, bad = 0, n = 0, g_edge = 0, d_edge = 0, rate = 50;
  logic [DW-1:0] ref_mem [MW];
  logic [DW-1:0] exp_rdata = '0, t_rd = '0, t_wd = '0;
  logic [31:0] t_addr = '0;
  logic act = 1'b0, t_port = 1'b0, t_we = 1'b0, t_oor = 1'b0, ptr = 1'b1, auto_on = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  task automatic new_req(output logic r, output logic w, output logic [31:0] a, output logic [DW-1:0] d);
    r = 1'b1;
    w = 1'($urandom_range(0, 1));
    a = ($urandom_range(0, 9) == 0) ? 32'h100 + 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 255));
    d = $urandom;
  endtask
  task automatic step();
    logic p0, p1, pr, w;
    logic eg0, eg1, ed0, ed1, er, eb, erd, ewr;
    p0 = req0; p1 = req1; pr = reset;
    {eg0, eg1, ed0, ed1, er, eb, erd, ewr} = '0;
    @(posedge clk);
    n++;
    @(negedge clk);
    if (pr) begin
      act = 1'b0; ptr = 1'b1; exp_rdata = '0;
    end else begin
      if (act && n == d_edge) begin ed0 = !t_port; ed1 = t_port; er = t_oor; end
      if ((!act || n > d_edge) && (p0 || p1)) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (p0 && p1) ? !ptr : p1;
`else
        w = !p0;
`endif
        eg0 = !w; eg1 = w; ptr = w; act = 1'b1; g_edge = n; t_port = w;
        t_we = w ? we1 : we0;
        t_addr = w ? addr1 : addr0;
        t_wd = w ? wdata1 : wdata0;
        t_oor = (t_addr >> 2) >= MW;
        d_edge = n + (t_oor ? 1 : AC + 1);
        if (!t_oor) begin
          if (t_we) ref_mem[int'(t_addr >> 2)] = t_wd;
          t_rd = ref_mem[int'(t_addr >> 2)];
        end
      end
      if (act && !t_oor && !t_we && n == g_edge + AC) exp_rdata = t_rd;
      eb = act && n >= g_edge && n < d_edge;
      erd = act && !t_oor && !t_we && n >= g_edge && n < g_edge + AC;
      ewr = act && !t_oor && t_we && n == g_edge;
    end
    check("ctl{gnt0,gnt1,done0,done1,rerr,busy,ren,wen}",
          {gnt0, gnt1, done0, done1, range_err, busy, ram_read_en, ram_write_en},
          {eg0, eg1, ed0, ed1, er, eb, erd, ewr});
    check("rdata", rdata, exp_rdata);
    if (erd || ewr) check("ram_address", ram_address, t_addr);
    if (ewr) check("ram_data_write", ram_data_write, t_wd);
    if (pr) begin
      check("reset ram_address", ram_address, 0);
      check("reset ram_data_write", ram_data_write, 0);
    end
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
    if (auto_on && !req0 && $urandom_range(0, 99) < rate) new_req(req0, we0, addr0, wdata0);
    if (auto_on && !req1 && $urandom_range(0, 99) < rate) new_req(req1, we1, addr1, wdata1);
  endtask
  initial begin
    bit seen;
    @(negedge clk);
    for (int i = 0; i < MW; i++) begin
      fill = 1'b1; fill_idx = i; fill_val = $urandom; ref_mem[i] = fill_val;
      @(negedge clk);
    end
    fill = 1'b0;
    step();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
    for (int i = 0; i < 6; i++) step();
    check("directed read 0x8", rdata, 32'hDEADBEEF);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100;
    for (int i = 0; i < 4; i++) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1C;
    for (int i = 0; i < 12; i++) step();
    auto_on = 1'b1;
    rate = 50;
    for (int i = 0; i < 1500; i++) step();
    rate = 100;
    for (int i = 0; i < 500; i++) step();
    auto_on = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = gnt0;
    end
    check("reset test grant seen", seen, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    for (int i = 0; i < 6; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
